frac_clken_gen: RTL and testbench
=================================

# frac_clken_gen

Multi-channel fractional clock-enable generator, the parametrised successor to the single-output fixed-ratio pixel-clock PLL wrapper. It derives up to NUM_CH independent enable strobes from the single reference clock using per-channel phase accumulators, for example a 25.175644 MHz-average pixel enable from 50 MHz. Ratio and phase are reprogrammable at runtime through a valid/ready port, and a lock indicator mirrors the PLL `locked` semantics. It sits beside the PLL in the clocking block and feeds the video, audio and timer domains as clock enables on `refclk`.

## Interface
- NUM_CH, 4, number of enable channels (1-16)
- ACC_W, 32, phase accumulator width; output rate = f_refclk * inc / 2^ACC_W
- LOCK_CYCLES, 16, settle cycles before `locked` (re)asserts (>=1)
- INIT_INC, 2162571354, increment loaded into every channel at reset (25.175644 MHz from 50 MHz at ACC_W=32)
- CH_W, max(1,$clog2(NUM_CH)), derived channel-index width

Ports:
- refclk  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- cfg_valid  in  1  reconfiguration request
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
- cfg_ch  in  CH_W  target channel
- cfg_inc  in  ACC_W  new increment; 0 disables the channel
- cfg_phase  in  ACC_W  accumulator preload
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_ch >= NUM_CH
- clken  out  NUM_CH  per-channel one-cycle enable strobes
- tog  out  NUM_CH  per-channel toggle, flips on each clken (approx. 50% duty, data only)
- locked  out  1  all channels running at their programmed ratio

## Operation
- Reset (rst_n low at a refclk edge): acc[c]=0, inc[c]=INIT_INC, clken=0, tog=0, locked=0, cfg_ready=0, cfg_err=0, FSM=SETTLE, settle counter=0.
- Per channel, every cycle outside reset: {carry, acc_next} = acc + inc (ACC_W+1-bit add, modulo 2^ACC_W). clken[c] is registered carry. tog[c] flips in the same cycle clken[c] is high.
- inc=0: acc frozen, clken stays 0, tog holds its value.
- FSM:
  - SETTLE: counter increments each cycle. On counter==LOCK_CYCLES-1, go to LOCKED. cfg_ready=0, locked=0.
  - LOCKED: locked=1, cfg_ready=1. On an accepted request with valid cfg_ch, go to APPLY. On an accepted request with cfg_ch>=NUM_CH, pulse cfg_err, ignore the request, stay LOCKED (locked stays 1).
  - APPLY (one cycle): inc[cfg_ch]=captured cfg_inc, acc[cfg_ch]=captured cfg_phase. clken[cfg_ch] is forced 0 for that cycle. locked=0, cfg_ready=0. Clear the counter and go to SETTLE.
- Request fields are captured on the accept edge. Inputs are don't-care when not accepted.
- Untouched channels keep running uninterrupted through APPLY and SETTLE. Only `locked` drops globally.
- rst_n low in any state aborts the operation immediately and produces the reset values above. An in-flight request is lost.

## Timing
- Cycle 1 is the first edge with rst_n high. Accumulators add from cycle 1.
- clken latency: a carry produced by the add at edge k appears on clken during cycle k+1 (one register).
- locked first rises after LOCK_CYCLES cycles in SETTLE: high from cycle LOCK_CYCLES+1.
- Reconfig: accept at edge a; APPLY in cycle a+1; locked low from a+1; locked high again at a+2+LOCK_CYCLES.
- After APPLY, the reprogrammed channel's first add uses the new phase and inc.
- Accept rate: at most one request per LOCK_CYCLES+2 cycles (invalid-channel requests: one per cycle).

## Test plan
- Reset/lock (ACC_W=8, NUM_CH=2, INIT_INC=64, LOCK_CYCLES=4): release reset -> clken[0] and clken[1] first high in cycle 5, then every 4 cycles; locked high from cycle 5; cfg_ready=1 from cycle 5.
- Fractional ratio (ACC_W=8, inc=96): over 256 cycles -> exactly 96 clken pulses; spacing only 2 or 3 cycles; tog toggles 96 times.
- Reconfig with phase: accept ch1, inc=128, phase=128 -> locked drops next cycle for 1+LOCK_CYCLES cycles; ch1 strobes on alternate cycles starting 2 cycles after APPLY; ch0 cadence unbroken.
- Disable and invalid channel: inc=0 on ch0 -> clken[0] stays 0 and tog[0] frozen; request with cfg_ch=3 (NUM_CH=2) -> cfg_err one-cycle pulse, locked stays 1, no channel changes.
- Mid-operation reset: assert rst_n low during SETTLE after a reconfig -> next cycle all outputs at reset values and inc back to INIT_INC.
- Full-scale (ACC_W=32, default INIT_INC): over 10^6 cycles -> 503512 ±1 pulses.

Source files
------------

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators on refclk
// produce carry strobes (clken) and toggles; a valid/ready port reprograms ratio and phase.
module frac_clken_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 32,
  parameter int LOCK_CYCLES = 16,
  parameter longint unsigned INIT_INC = 64'd2162571354,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] tog,
  output logic              locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_APPLY  = 2'd2;

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  cap_ch;
  logic [ACC_W-1:0] cap_inc;
  logic [ACC_W-1:0] cap_phase;
  logic             accept;
  logic             ch_bad;

  assign cfg_ready = (state == ST_LOCKED);
  assign locked    = (state == ST_LOCKED);
  assign accept    = cfg_valid && cfg_ready;
  assign ch_bad    = 32'(cfg_ch) >= 32'(NUM_CH);

  // The carry of the add is the strobe; the channel being reloaded loses its strobe.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c] = {1'b0, acc[c]} + {1'b0, inc[c]};
      hit[c] = sum[c][ACC_W] && !((state == ST_APPLY) && (cap_ch == CH_W'(c)));
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        inc[c] <= ACC_W'(INIT_INC);
      end
      clken     <= '0;
      tog       <= '0;
      state     <= ST_SETTLE;
      cnt       <= '0;
      cfg_err   <= 1'b0;
      cap_ch    <= '0;
      cap_inc   <= '0;
      cap_phase <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((state == ST_APPLY) && (cap_ch == CH_W'(c))) begin
          acc[c] <= cap_phase;
          inc[c] <= cap_inc;
        end else begin
          acc[c] <= sum[c][ACC_W-1:0];
        end
      end
      clken   <= hit;
      tog     <= tog ^ hit;
      cfg_err <= 1'b0;
      case (state)
        ST_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_LOCKED;
        end
        ST_LOCKED: begin
          // Bad channel index is rejected in place so lock is never disturbed.
          if (accept) begin
            if (ch_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cap_ch    <= cfg_ch;
              cap_inc   <= cfg_inc;
              cap_phase <= cfg_phase;
              state     <= ST_APPLY;
            end
          end
        end
        ST_APPLY: begin
          cnt   <= '0;
          state <= ST_SETTLE;
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_clken_gen.sv
// Bench for frac_clken_gen: scoreboarded cycle model on a small 3-channel instance plus
// a long pulse-count run on a full-width default instance.
module tb_frac_clken_gen;
  localparam int N = 3;
  localparam int L = 4;
  localparam int NF = 50000;
  localparam longint unsigned FULL_INC = 64'd2162571354;

  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic       rst_n, cfg_valid, cfg_ready, cfg_err, locked;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_inc, cfg_phase;
  logic [2:0] clken, tog;

  logic       f_rst_n, f_ready, f_err, f_locked;
  logic [3:0] f_clken, f_tog;

  frac_clken_gen #(.NUM_CH(N), .ACC_W(8), .LOCK_CYCLES(L), .INIT_INC(64)) u_dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .clken(clken), .tog(tog), .locked(locked));

  frac_clken_gen u_full (
    .refclk(refclk), .rst_n(f_rst_n), .cfg_valid(1'b0), .cfg_ready(f_ready),
    .cfg_ch(2'd0), .cfg_inc(32'd0), .cfg_phase(32'd0), .cfg_err(f_err),
    .clken(f_clken), .tog(f_tog), .locked(f_locked));

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (0 settle, 1 locked, 2 apply)
  logic [7:0] m_acc [N];
  logic [7:0] m_inc [N];
  logic [2:0] m_clk, m_tog;
  int         m_st, m_cnt;
  logic       m_err;
  logic [1:0] c_ch;
  logic [7:0] c_inc, c_ph;
  logic [8:0] sb [$];

  task automatic step(input logic v, input logic [1:0] ch, input logic [7:0] ic,
                      input logic [7:0] ph, input logic rn);
    logic [8:0] s;
    logic [2:0] nclk;
    logic [8:0] e;
    rst_n = rn; cfg_valid = v; cfg_ch = ch; cfg_inc = ic; cfg_phase = ph;
    if (!rn) begin
      for (int c = 0; c < N; c++) begin m_acc[c] = 8'd0; m_inc[c] = 8'd64; end
      m_clk = '0; m_tog = '0; m_st = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      nclk = '0;
      for (int c = 0; c < N; c++) begin
        s = {1'b0, m_acc[c]} + {1'b0, m_inc[c]};
        nclk[c] = s[8];
        m_acc[c] = s[7:0];
      end
      if (m_st == 2) begin
        m_acc[c_ch] = c_ph; m_inc[c_ch] = c_inc; nclk[c_ch] = 1'b0;
      end
      m_tog = m_tog ^ nclk;
      m_clk = nclk;
      m_err = 1'b0;
      case (m_st)
        0: begin if (m_cnt == L - 1) m_st = 1; m_cnt++; end
        1: if (v) begin
             if (int'(ch) >= N) m_err = 1'b1;
             else begin c_ch = ch; c_inc = ic; c_ph = ph; m_st = 2; end
           end
        default: begin m_cnt = 0; m_st = 0; end
      endcase
    end
    sb.push_back({m_st == 1, m_err, m_st == 1, m_tog, m_clk});
    @(posedge refclk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else begin
      e = sb.pop_front();
      chk("outputs", {cfg_ready, cfg_err, locked, tog, clken}, e);
    end
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
  endtask

  task automatic req(input logic [1:0] ch, input logic [7:0] ic, input logic [7:0] ph);
    for (int i = 0; i < 30 && m_st != 1; i++) idle();
    chk("req_ready", cfg_ready, 1);
    step(1'b1, ch, ic, ph, 1'b1);
  endtask

  task automatic first_strobes(input string tag);
    int f0, f2, fl, fr, n0;
    f0 = 0; f2 = 0; fl = 0; fr = 0; n0 = 0;
    for (int k = 1; k <= 12; k++) begin
      idle();
      if (clken[0]) n0++;
      if (clken[0] && f0 == 0) f0 = k + 1;
      if (clken[2] && f2 == 0) f2 = k + 1;
      if (locked && fl == 0) fl = k + 1;
      if (cfg_ready && fr == 0) fr = k + 1;
    end
    chk({tag, "_first_clken0"}, f0, 5);
    chk({tag, "_first_clken2"}, f2, 5);
    chk({tag, "_first_locked"}, fl, 5);
    chk({tag, "_first_ready"}, fr, 5);
    chk({tag, "_clken0_count"}, n0, 3);
  endtask

  task automatic run_main();
    int npulse, ntog, last, badgap, nlow;
    logic prev;
    logic [12:0] pat, pexp;
    // Reset and first lock
    repeat (2) step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    chk("rst_clken", clken, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", cfg_ready, 0);
    first_strobes("boot");

    // Fractional ratio 96/256
    req(2'd0, 8'd96, 8'd0);
    for (int i = 0; i < 30 && !locked; i++) idle();
    chk("relock", locked, 1);
    npulse = 0; ntog = 0; last = -1; badgap = 0; prev = tog[0];
    for (int i = 0; i < 256; i++) begin
      idle();
      if (clken[0]) begin
        npulse++;
        if (last >= 0 && (i - last < 2 || i - last > 3)) badgap++;
        last = i;
      end
      if (tog[0] != prev) ntog++;
      prev = tog[0];
    end
    chk("frac_pulses", npulse, 96);
    chk("frac_badgap", badgap, 0);
    chk("frac_toggles", ntog, 96);

    // Reconfigure ch1 with phase preload
    req(2'd1, 8'd128, 8'd128);
    pat = '0; pexp = '0; nlow = 0;
    for (int idx = 1; idx <= 12; idx++) begin
      if (idx > 1) idle();
      if (!locked) nlow++;
      pat[idx] = clken[1];
      pexp[idx] = (idx >= 3) && (idx % 2 == 1);
    end
    chk("reconf_lock_low", nlow, L + 1);
    chk("reconf_ch1_pattern", pat, pexp);

    // Disable ch0
    req(2'd0, 8'd0, 8'd0);
    idle(); idle();
    prev = tog[0]; npulse = 0; ntog = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (clken[0]) npulse++;
      if (tog[0] != prev) ntog++;
    end
    chk("dis_clken0", npulse, 0);
    chk("dis_tog0", ntog, 0);

    // Invalid channel, back to back
    for (int i = 0; i < 30 && m_st != 1; i++) idle();
    step(1'b1, 2'd3, 8'd1, 8'd1, 1'b1);
    chk("err_pulse", cfg_err, 1);
    chk("err_locked", locked, 1);
    step(1'b1, 2'd3, 8'd2, 8'd2, 1'b1);
    chk("err_pulse2", cfg_err, 1);
    idle();
    chk("err_clear", cfg_err, 0);
    chk("err_locked2", locked, 1);

    // Reset in the middle of settling
    req(2'd2, 8'd32, 8'd0);
    idle(); idle();
    chk("mid_settle", locked, 0);
    step(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    chk("mid_rst_clken", clken, 0);
    chk("mid_rst_tog", tog, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_ready", cfg_ready, 0);
    chk("mid_rst_err", cfg_err, 0);
    first_strobes("post");
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic run_full();
    int n0, n3;
    logic [63:0] exp;
    f_rst_n = 1'b0;
    repeat (2) @(posedge refclk);
    #1 f_rst_n = 1'b1;
    n0 = 0; n3 = 0;
    for (int i = 0; i < NF; i++) begin
      @(posedge refclk);
      #1;
      if (f_clken[0]) n0++;
      if (f_clken[3]) n3++;
    end
    exp = (64'(NF) * FULL_INC) >> 32;
    chk("full_ch0_pulses", n0, exp);
    chk("full_ch3_pulses", n3, exp);
    chk("full_locked", f_locked, 1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
    f_rst_n = 1'b0;
    fork
      run_main();
      run_full();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
